// File: rtl/bandgap_power_ctrl.sv
// Power sequencer and request arbiter for the 3.3V analog bandgap reference.
// Merges consumer requests, times the settling window and the power-down hold-off.
module bandgap_power_ctrl #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 64,
    parameter int CW            = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            force_on,
    input  logic            pd_override,
    output logic            bg_en,
    output logic            bg_ready,
    output logic [NREQ-1:0] ack,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          cur_state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   next_count;
    logic            want;

    assign want  = ((|req) | force_on) & ~pd_override;
    assign state = cur_state;

    // pd_override already clears want, so any !want branch below also covers it
    always_comb begin
        next_state = cur_state;
        next_count = count;
        case (cur_state)
            ST_OFF: begin
                if (want) begin
                    next_state = ST_SETTLE;
                    next_count = CW'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (!want) begin
                    next_state = ST_OFF;
                end else if (count == '0) begin
                    next_state = ST_ON;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            ST_ON: begin
                if (!want) begin
                    if (pd_override) begin
                        next_state = ST_OFF;
                    end else begin
                        next_state = ST_HOLD;
                        next_count = CW'(HOLD_CYCLES - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (pd_override) begin
                    next_state = ST_OFF;
                end else if (want) begin
                    next_state = ST_ON;
                end else if (count == '0) begin
                    next_state = ST_OFF;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            default: begin
                next_state = ST_OFF;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_OFF;
            count     <= '0;
            bg_en     <= 1'b0;
            bg_ready  <= 1'b0;
            ack       <= '0;
        end else begin
            cur_state <= next_state;
            count     <= next_count;
            bg_en     <= (next_state != ST_OFF);
            bg_ready  <= (next_state == ST_ON) || (next_state == ST_HOLD);
            ack       <= req & {NREQ{next_state == ST_ON}};
        end
    end

endmodule

// File: tb/tb_bandgap_power_ctrl.sv
// Directed table-driven bench for bandgap_power_ctrl (SETTLE=8, HOLD=4).
// Each record holds inputs for n cycles; outputs are checked after every cycle.
module tb_bandgap_power_ctrl;

    localparam int NREQ   = 4;
    localparam int SETTLE = 8;
    localparam int HOLD   = 4;
    localparam int CW     = 8;

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            force_on;
    logic            pd_override;
    logic            bg_en;
    logic            bg_ready;
    logic [NREQ-1:0] ack;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] rq;
        logic            frc;
        logic            pd;
        int              n;
        logic [1:0]      st;
        logic            en;
        logic            rdy;
        logic [NREQ-1:0] ak;
    } vec_t;

    vec_t vecs[$];

    bandgap_power_ctrl #(
        .NREQ(NREQ), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .force_on(force_on),
        .pd_override(pd_override), .bg_en(bg_en), .bg_ready(bg_ready),
        .ack(ack), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [NREQ-1:0] rq, input logic frc,
                       input logic pd, input int n, input logic [1:0] st,
                       input logic en, input logic rdy, input logic [NREQ-1:0] ak);
        vec_t v;
        v.rst = rst; v.rq = rq; v.frc = frc; v.pd = pd; v.n = n;
        v.st = st; v.en = en; v.rdy = rdy; v.ak = ak;
        vecs.push_back(v);
    endtask

    task automatic check_invariants(input int idx);
        check("ready_implies_en", idx, {7'd0, bg_ready & ~bg_en}, 8'd0);
        check("ack_implies_ready", idx, {7'd0, (|ack) & ~bg_ready}, 8'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; req = '0; force_on = 1'b0; pd_override = 1'b0;

        // rst req frc pd n  state   en rdy ack
        add(1, 4'b0000, 0, 0, 2, S_OFF,    0, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 3, S_OFF,    0, 0, 4'b0000);
        // power-up latency
        add(0, 4'b0001, 0, 0, 8, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 1, S_ON,     1, 1, 4'b0001);
        add(0, 4'b0001, 0, 0, 3, S_ON,     1, 1, 4'b0001);
        // new requester acked one cycle later
        add(0, 4'b0011, 0, 0, 1, S_ON,     1, 1, 4'b0011);
        // power-down hold-off
        add(0, 4'b0000, 0, 0, 4, S_HOLD,   1, 1, 4'b0000);
        add(0, 4'b0000, 0, 0, 1, S_OFF,    0, 0, 4'b0000);
        // re-request during HOLD: back to ON with no settle
        add(0, 4'b0001, 0, 0, 8, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 1, S_ON,     1, 1, 4'b0001);
        add(0, 4'b0000, 0, 0, 2, S_HOLD,   1, 1, 4'b0000);
        add(0, 4'b0100, 0, 0, 1, S_ON,     1, 1, 4'b0100);
        add(0, 4'b0100, 0, 0, 1, S_ON,     1, 1, 4'b0100);
        add(0, 4'b0000, 0, 0, 4, S_HOLD,   1, 1, 4'b0000);
        add(0, 4'b0000, 0, 0, 1, S_OFF,    0, 0, 4'b0000);
        // abort SETTLE at counter=3, then full restart
        add(0, 4'b0001, 0, 0, 5, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 1, S_OFF,    0, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 8, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 1, S_ON,     1, 1, 4'b0001);
        // pd_override from ON, then release
        add(0, 4'b1111, 0, 0, 1, S_ON,     1, 1, 4'b1111);
        add(0, 4'b1111, 0, 1, 3, S_OFF,    0, 0, 4'b0000);
        add(0, 4'b1111, 0, 0, 8, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b1111, 0, 0, 1, S_ON,     1, 1, 4'b1111);
        // pd_override from HOLD and from SETTLE
        add(0, 4'b0000, 0, 0, 2, S_HOLD,   1, 1, 4'b0000);
        add(0, 4'b0000, 0, 1, 1, S_OFF,    0, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, 3, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0001, 0, 1, 1, S_OFF,    0, 0, 4'b0000);
        // force_on alone: ON with no acks
        add(0, 4'b0000, 1, 0, 8, S_SETTLE, 1, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 4, S_ON,     1, 1, 4'b0000);
        add(0, 4'b0010, 1, 0, 1, S_ON,     1, 1, 4'b0010);
        // request arrives on the edge HOLD would expire
        add(0, 4'b0000, 0, 0, 4, S_HOLD,   1, 1, 4'b0000);
        add(0, 4'b1000, 0, 0, 1, S_ON,     1, 1, 4'b1000);
        // reset mid-ON drops everything at once
        add(1, 4'b1000, 0, 0, 2, S_OFF,    0, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 2, S_OFF,    0, 0, 4'b0000);

        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            req         = vecs[i].rq;
            force_on    = vecs[i].frc;
            pd_override = vecs[i].pd;
            for (int c = 0; c < vecs[i].n; c++) begin
                step();
                check("state", i, {6'd0, state}, {6'd0, vecs[i].st});
                check("bg_en", i, {7'd0, bg_en}, {7'd0, vecs[i].en});
                check("bg_ready", i, {7'd0, bg_ready}, {7'd0, vecs[i].rdy});
                check("ack", i, {4'd0, ack}, {4'd0, vecs[i].ak});
                check_invariants(i);
            end
        end

        // Latency sequence: bg_ready must rise exactly SETTLE+1 edges after req is sampled
        req = 4'b0010;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!bg_ready && cyc < 50);
        check("powerup_latency", 100, 8'(cyc), 8'(SETTLE + 1));
        check("powerup_ack", 100, {4'd0, ack}, 8'h02);

        // Power-down sequence: bg_en must fall exactly HOLD+1 edges after last req drops
        req = 4'b0000;
        cyc = 0;
        do begin
            step();
            cyc++;
            check_invariants(101);
        end while (bg_en && cyc < 50);
        check("powerdown_latency", 101, 8'(cyc), 8'(HOLD + 1));
        check("powerdown_state", 101, {6'd0, state}, {6'd0, S_OFF});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
